alu_ctrl_md: RTL and testbench

- Next-generation ALU control for the MIPS execute stage.
- Registers the ALUop/func decode and pulses Jr for one cycle only; Jr is never sticky.
- Adds an iterative multiply/divide unit with HI/LO registers, plus a stall handshake to the pipeline.
- Sits between the main control/ID-EX register and the ALU, and supplies HI/LO for MFHI/MFLO.

---
 rtl/alu_ctrl_pkg.sv | 53 +++++
 rtl/alu_ctrl_md_md_unit.sv | 130 +++++++++++++
 rtl/alu_ctrl_md.sv | 92 +++++++++
 tb/tb_alu_ctrl_md.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the execute-stage ALU control: ALUop classes, ALU op codes,
// R-type func codes and the multiply/divide sequencer states.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // MULT/MULTU/DIV/DIVU share the 0110xx pattern.
    function automatic logic is_muldiv(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

    // Everything that touches HI/LO and therefore must wait for the sequencer.
    function automatic logic is_md_func(input logic [5:0] fn);
        return is_muldiv(fn) || (fn[5:2] == 4'b0100);
    endfunction

endpackage

// File: rtl/alu_ctrl_md_md_unit.sv
// Iterative multiply/divide sequencer with HI/LO registers: shift-add multiply,
// restoring divide on magnitudes, sign correction in a final cycle.
//
// state   | meaning
// MD_IDLE | waiting; accepts MULT/DIV and MTHI/MTLO writes
// MD_RUN  | one multiply or divide step per cycle, WIDTH steps
// MD_FIX  | sign correction; HI/LO written on the exit edge
module md_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             md_busy,
    output logic             md_done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_e state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] p_hi, p_lo, mcand;
    logic             op_div, div0, neg_q, neg_r;

    logic             op_signed, a_neg, b_neg, rt_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign op_signed = ~md_op[0];
    assign a_neg     = op_signed & rs_val[WIDTH-1];
    assign b_neg     = op_signed & rt_val[WIDTH-1];
    assign a_mag     = a_neg ? -rs_val : rs_val;
    assign b_mag     = b_neg ? -rt_val : rt_val;
    assign rt_zero   = (rt_val == '0);

    assign mul_sum  = {1'b0, p_hi} + {1'b0, (p_lo[0] ? mcand : '0)};
    assign trial    = {p_hi, p_lo[WIDTH-1]} - {1'b0, mcand};
    assign prod     = {p_hi, p_lo};
    assign prod_fix = neg_q ? -prod : prod;

    assign md_busy = (state != MD_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_RUN;
            MD_RUN:  if (count == '0) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // A zero divisor keeps the raw dividend so the remainder comes out as rs unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            mcand  <= '0;
            op_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (state == MD_IDLE && start) begin
            count  <= CW'(WIDTH - 1);
            p_hi   <= '0;
            p_lo   <= (md_op[1] && rt_zero) ? rs_val : a_mag;
            mcand  <= b_mag;
            op_div <= md_op[1];
            div0   <= md_op[1] & rt_zero;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
        end else if (state == MD_RUN) begin
            count <= count - 1'b1;
            if (!op_div) begin
                p_hi <= mul_sum[WIDTH:1];
                p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end else if (!trial[WIDTH]) begin
                p_hi <= trial[WIDTH-1:0];
                p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
                p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
                p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            md_done  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            md_done <= (state == MD_FIX);
            if (state == MD_FIX) begin
                if (!op_div) begin
                    {hi, lo} <= prod_fix;
                end else if (div0) begin
                    hi       <= p_hi;
                    lo       <= '1;
                    div_zero <= 1'b1;
                end else begin
                    hi <= neg_r ? -p_hi : p_hi;
                    lo <= neg_q ? -p_lo : p_lo;
                end
            end else if (state == MD_IDLE) begin
                if (start)   div_zero <= 1'b0;
                if (mthi_we) hi <= rs_val;
                if (mtlo_we) lo <= rs_val;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// Execute-stage ALU control: registered ALUop/func decode with one-cycle Jr/illegal
// pulses, pipeline stall for HI/LO hazards, and the multiply/divide unit.
module alu_ctrl_md
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [OPW-1:0]   alu_operation,
    output logic             Jr,
    output logic             illegal,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic           accept, rtype;
    logic [OPW-1:0] op_nxt;
    logic           jr_nxt, ill_nxt;

    assign rtype  = (ALUop == ALUOP_RTYPE);
    assign stall  = md_busy & valid_i & rtype & is_md_func(func);
    assign accept = valid_i & ~stall;

    always_comb begin
        op_nxt  = alu_operation;
        jr_nxt  = 1'b0;
        ill_nxt = 1'b0;
        if (accept) begin
            case (ALUop)
                ALUOP_ADD: op_nxt = OPW'(OP_ADD);
                ALUOP_SUB: op_nxt = OPW'(OP_SUB);
                ALUOP_AND: op_nxt = OPW'(OP_AND);
                default: begin
                    case (func)
                        F_ADD: op_nxt = OPW'(OP_ADD);
                        F_SUB: op_nxt = OPW'(OP_SUB);
                        F_AND: op_nxt = OPW'(OP_AND);
                        F_OR:  op_nxt = OPW'(OP_OR);
                        F_NOR: op_nxt = OPW'(OP_NOR);
                        F_SLT: op_nxt = OPW'(OP_SLT);
                        F_SLL: op_nxt = OPW'(OP_SLL);
                        F_SRL: op_nxt = OPW'(OP_SRL);
                        F_JR:  jr_nxt = 1'b1;
                        default: begin
                            op_nxt  = OPW'(OP_ADD);
                            ill_nxt = ~is_md_func(func);
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_operation <= OPW'(OP_ADD);
            Jr            <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            alu_operation <= op_nxt;
            Jr            <= jr_nxt;
            illegal       <= ill_nxt;
        end
    end

    md_unit #(.WIDTH(WIDTH)) u_md (
        .clk      (clk),
        .reset    (reset),
        .start    (accept & rtype & is_muldiv(func)),
        .md_op    (func[1:0]),
        .mthi_we  (accept & rtype & (func == F_MTHI)),
        .mtlo_we  (accept & rtype & (func == F_MTLO)),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode, Jr/illegal pulses, multiply/divide results,
// stall handshake and asynchronous reset during a divide.
module tb_alu_ctrl_md;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [1:0]  ALUop = 2'b00;
    logic [5:0]  func = 6'b0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [3:0]  alu_operation;
    logic        Jr, illegal, stall, md_busy, md_done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    alu_ctrl_md #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ALUop(ALUop), .func(func),
        .rs_val(rs_val), .rt_val(rt_val), .alu_operation(alu_operation), .Jr(Jr),
        .illegal(illegal), .stall(stall), .md_busy(md_busy), .md_done(md_done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1; ALUop = op; func = fn; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz);
        int c;
        issue(2'b10, fn, a, b);
        chk({tag, "_busy"}, md_busy, 1);
        c = 0;
        while (md_busy && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_cycles"}, c, 33);
        chk({tag, "_done"}, md_done, 1);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_dz"}, div_zero, edz);
        @(posedge clk); #1;
        chk({tag, "_done_off"}, md_done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op", alu_operation, 4'b0010);
        chk("rst_jr", Jr, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(2'b10, 6'b100101, 0, 0);
        chk("or_op", alu_operation, 4'b0001);
        chk("or_jr", Jr, 0);
        issue(2'b11, 6'b000000, 0, 0);
        chk("andi_op", alu_operation, 4'b0000);
        issue(2'b10, 6'b001000, 0, 0);
        chk("jr_pulse", Jr, 1);
        chk("jr_op_hold", alu_operation, 4'b0000);
        issue(2'b00, 6'b000000, 0, 0);
        chk("jr_clear", Jr, 0);
        chk("add_op", alu_operation, 4'b0010);
        issue(2'b01, 6'b000000, 0, 0);
        chk("sub_op", alu_operation, 4'b0110);
        issue(2'b10, 6'b101010, 0, 0);
        chk("slt_op", alu_operation, 4'b0111);
        issue(2'b10, 6'b000010, 0, 0);
        chk("srl_op", alu_operation, 4'b0100);
        issue(2'b10, 6'b100111, 0, 0);
        chk("nor_op", alu_operation, 4'b1100);
        issue(2'b10, 6'b111111, 0, 0);
        chk("ill_pulse", illegal, 1);
        chk("ill_op", alu_operation, 4'b0010);
        @(posedge clk); #1;
        chk("ill_clear", illegal, 0);
        chk("idle_hold", alu_operation, 4'b0010);

        issue(2'b10, 6'b010001, 32'h0000_1234, 0);
        chk("mthi", hi, 32'h0000_1234);
        issue(2'b10, 6'b010011, 32'h0000_5678, 0);
        chk("mtlo", lo, 32'h0000_5678);

        run_md("mult",  6'b011000, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_md("multu", 6'b011001, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, 0);
        run_md("div",   6'b011010, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_md("divu0", 6'b011011, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, 1);
        run_md("divmin", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);

        // MULT in flight: unrelated ALU ops proceed, MFLO is held off
        issue(2'b10, 6'b011000, 32'd4, 32'd5);
        issue(2'b10, 6'b100101, 0, 0);
        chk("busy_or", alu_operation, 4'b0001);
        issue(2'b00, 6'b000000, 0, 0);
        chk("busy_add_stall", stall, 0);
        chk("busy_add_op", alu_operation, 4'b0010);
        issue(2'b10, 6'b100101, 0, 0);
        valid_i = 1'b1; ALUop = 2'b10; func = 6'b010010;
        #1;
        chk("mflo_stall", stall, 1);
        @(posedge clk); #1;
        chk("mflo_hold", alu_operation, 4'b0001);
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mflo_release", stall, 0);
        chk("mflo_done", md_done, 1);
        chk("mflo_lo", lo, 32'd20);
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("mflo_taken", alu_operation, 4'b0010);

        issue(2'b10, 6'b011010, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        chk("rdiv_busy", md_busy, 1);
        reset = 1'b1;
        #1;
        chk("rdiv_busy_off", md_busy, 0);
        chk("rdiv_hi", hi, 0);
        chk("rdiv_lo", lo, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_md("mult35", 6'b011000, 32'd3, 32'd5, 32'd0, 32'd15, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
